// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state encoding, ALU select bits and IR field positions
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_t;

    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RA_HI     = 26;
    localparam int RA_LO     = 23;
    localparam int RB_HI     = 22;
    localparam int RB_LO     = 19;
    localparam int RC_HI     = 18;
    localparam int RC_LO     = 15;

    typedef enum logic [2:0] {
        CLS_TWO, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL: return CLS_TWO;
            OP_DIV, OP_MUL:          return CLS_MULDIV;
            OP_NEG, OP_NOT:          return CLS_UNARY;
            OP_NOP:                  return CLS_NOP;
            OP_HALT:                 return CLS_HALT;
            default:                 return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu_index(input logic [4:0] op);
        case (op)
            OP_AND:  return 4'(ALU_AND);
            OP_OR:   return 4'(ALU_OR);
            OP_ADD:  return 4'(ALU_ADD);
            OP_SUB:  return 4'(ALU_SUB);
            OP_MUL:  return 4'(ALU_MUL);
            OP_DIV:  return 4'(ALU_DIV);
            OP_SHR:  return 4'(ALU_SHR);
            OP_SHRA: return 4'(ALU_SHRA);
            OP_SHL:  return 4'(ALU_SHL);
            OP_ROR:  return 4'(ALU_ROR);
            OP_ROL:  return 4'(ALU_ROL);
            OP_NEG:  return 4'(ALU_NEG);
            OP_NOT:  return 4'(ALU_NOT);
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index to 16-bit one-hot strobe with enable
module reg_select_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - hard-wired fetch/execute control unit for the single-bus datapath
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stop,
    input  logic [31:0]         ir,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [15:0]         reg_in,
    output logic [15:0]         reg_out,
    output logic [ALU_W-1:0]    alu_op,
    output logic                run,
    output logic                illegal
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    op_class_t  op_class;
    logic [3:0] alu_idx;
    logic       reg_in_en, reg_out_en;
    logic [3:0] reg_in_idx, reg_out_idx;
    logic       instr_end;
    logic       unused_ir_bits;

    assign opcode         = ir[OPCODE_HI:OPCODE_LO];
    assign ra             = ir[RA_HI:RA_LO];
    assign rb             = ir[RB_HI:RB_LO];
    assign rc             = ir[RC_HI:RC_LO];
    assign op_class       = classify(opcode);
    assign alu_idx        = alu_index(opcode);
    assign unused_ir_bits = ^ir[RC_LO-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RST;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_T1 && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        pc_out      = 1'b0;
        mar_in      = 1'b0;
        inc_pc      = 1'b0;
        pc_in       = 1'b0;
        read        = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlow_out    = 1'b0;
        zhigh_out   = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        alu_op      = '0;
        run         = 1'b0;
        illegal     = 1'b0;
        reg_in_en   = 1'b0;
        reg_in_idx  = ra;
        reg_out_en  = 1'b0;
        reg_out_idx = rb;
        instr_end   = 1'b0;

        case (state)
            ST_RST: state_next = ST_T0;
            ST_T0: begin
                run        = 1'b1;
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                pc_in      = 1'b1;
                state_next = ST_T1;
            end
            ST_T1: begin
                run    = 1'b1;
                read   = 1'b1;
                mdr_in = 1'b1;
                if (wait_cnt == WAIT_LIMIT) begin
                    state_next = ST_T2;
                end
            end
            ST_T2: begin
                run        = 1'b1;
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = ST_T3;
            end
            ST_T3: begin
                run = 1'b1;
                case (op_class)
                    CLS_TWO, CLS_MULDIV: begin
                        reg_out_en = 1'b1;
                        y_in       = 1'b1;
                        state_next = ST_T4;
                    end
                    CLS_UNARY: begin
                        reg_out_en      = 1'b1;
                        alu_op[alu_idx] = 1'b1;
                        z_in            = 1'b1;
                        state_next      = ST_T4;
                    end
                    CLS_HALT:    state_next = ST_HALT;
                    CLS_ILLEGAL: begin
                        illegal   = 1'b1;
                        instr_end = 1'b1;
                    end
                    default:     instr_end = 1'b1;
                endcase
            end
            ST_T4: begin
                run = 1'b1;
                if (op_class == CLS_UNARY) begin
                    zlow_out  = 1'b1;
                    reg_in_en = 1'b1;
                    instr_end = 1'b1;
                end else begin
                    reg_out_en      = 1'b1;
                    reg_out_idx     = rc;
                    alu_op[alu_idx] = 1'b1;
                    z_in            = 1'b1;
                    state_next      = ST_T5;
                end
            end
            ST_T5: begin
                run      = 1'b1;
                zlow_out = 1'b1;
                if (op_class == CLS_MULDIV) begin
                    lo_in      = 1'b1;
                    state_next = ST_T6;
                end else begin
                    reg_in_en = 1'b1;
                    instr_end = 1'b1;
                end
            end
            ST_T6: begin
                run       = 1'b1;
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                instr_end = 1'b1;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase

        // stop only matters at an instruction boundary
        if (instr_end) begin
            state_next = stop ? ST_HALT : ST_T0;
        end
    end

    reg_select_decoder u_reg_in_dec (
        .idx    (reg_in_idx),
        .en     (reg_in_en),
        .onehot (reg_in)
    );

    reg_select_decoder u_reg_out_dec (
        .idx    (reg_out_idx),
        .en     (reg_out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - bench for alu_control_sequencer with MEM_WAIT 0 and 2 instances
module tb_alu_control_sequencer;

    typedef struct packed {
        logic run, illegal, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
        logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
        logic [15:0] reg_in, reg_out;
        logic [12:0] alu_op;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_v[2];
    logic        stop_v[2];
    logic [31:0] ir_v[2];
    outs_t       act[2];
    int          errors = 0;
    int          checks = 0;
    logic        armed = 1'b0;

    logic m_rst[2]  = '{1'b1, 1'b1};
    logic m_halt[2] = '{1'b0, 1'b0};
    int   m_idx[2]  = '{0, 0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
        logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, run, illegal;
        logic [15:0] reg_in, reg_out;
        logic [12:0] alu_op;
        alu_control_sequencer #(.MEM_WAIT(2 * g)) dut (
            .clk(clk), .reset(reset_v[g]), .stop(stop_v[g]), .ir(ir_v[g]),
            .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
            .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
            .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
            .hi_in(hi_in), .lo_in(lo_in), .reg_in(reg_in), .reg_out(reg_out),
            .alu_op(alu_op), .run(run), .illegal(illegal)
        );
        assign act[g] = {run, illegal, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                         y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, reg_in, reg_out, alu_op};
    end

    // 0 two-operand, 1 mul/div, 2 unary, 3 nop, 4 halt, 5 illegal
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 0;
            5'd15, 5'd16: return 1;
            5'd17, 5'd18: return 2;
            5'd26:        return 3;
            5'd27:        return 4;
            default:      return 5;
        endcase
    endfunction

    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            5'd5: return 0;   5'd6: return 1;   5'd3: return 2;   5'd4: return 3;
            5'd16: return 4;  5'd15: return 5;  5'd9: return 6;   5'd10: return 7;
            5'd11: return 8;  5'd7: return 9;   5'd8: return 10;  5'd17: return 11;
            default: return 12;
        endcase
    endfunction

    function automatic int nsteps(input logic [31:0] i, input int w);
        case (op_class(i[31:27]))
            0: return w + 6;
            1: return w + 7;
            2: return w + 5;
            default: return w + 4;
        endcase
    endfunction

    // Expected outputs at cycle idx of an instruction counted from its T0 cycle
    function automatic outs_t step_vec(input logic [31:0] i, input int w, input int idx);
        outs_t s;
        int cls, e;
        logic [15:0] ra1, rb1, rc1;
        logic [12:0] alu1;
        s = '0;
        s.run = 1'b1;
        cls = op_class(i[31:27]);
        ra1 = 16'(1) << i[26:23];
        rb1 = 16'(1) << i[22:19];
        rc1 = 16'(1) << i[18:15];
        alu1 = 13'(1) << alu_bit(i[31:27]);
        e = idx - (w + 3);
        if (idx == 0) {s.pc_out, s.mar_in, s.inc_pc, s.pc_in} = 4'hF;
        else if (idx <= w + 1) {s.read, s.mdr_in} = 2'b11;
        else if (idx == w + 2) {s.mdr_out, s.ir_in} = 2'b11;
        else if (cls <= 1) begin
            case (e)
                0: begin s.reg_out = rb1; s.y_in = 1'b1; end
                1: begin s.reg_out = rc1; s.alu_op = alu1; s.z_in = 1'b1; end
                2: begin
                    s.zlow_out = 1'b1;
                    if (cls == 0) s.reg_in = ra1;
                    else s.lo_in = 1'b1;
                end
                default: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
            endcase
        end else if (cls == 2) begin
            if (e == 0) begin s.reg_out = rb1; s.alu_op = alu1; s.z_in = 1'b1; end
            else begin s.zlow_out = 1'b1; s.reg_in = ra1; end
        end else if (cls == 5) s.illegal = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [4:0] legal[14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
        int r;
        logic [4:0] op;
        r = int'($urandom_range(0, 19));
        if (r < 16) op = legal[$urandom_range(0, 13)];
        else if (r < 17) op = 5'd27;
        else op = 5'($urandom_range(0, 31));
        return {op, 27'($urandom)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_v[k]) begin
                m_rst[k] <= 1'b1; m_halt[k] <= 1'b0; m_idx[k] <= 0;
            end else if (m_rst[k]) begin
                m_rst[k] <= 1'b0; m_idx[k] <= 0;
            end else if (!m_halt[k]) begin
                if (m_idx[k] == nsteps(ir_v[k], 2 * k) - 1) begin
                    m_idx[k] <= 0;
                    if (stop_v[k] || op_class(ir_v[k][31:27]) == 4) m_halt[k] <= 1'b1;
                end else begin
                    m_idx[k] <= m_idx[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                outs_t exp_v;
                exp_v = (m_rst[k] || m_halt[k]) ? '0 : step_vec(ir_v[k], 2 * k, m_idx[k]);
                checks++;
                if (act[k] !== exp_v) begin
                    errors++;
                    $display("FAIL model_dut%0d t=%0t ir=%h got %h expected %h",
                             k, $time, ir_v[k], act[k], exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic lit(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    localparam logic [31:0] IR_SHRA = 32'h521B8000;
    localparam logic [31:0] IR_MUL  = 32'h80188000;
    localparam logic [31:0] IR_NEG  = 32'h88900000;
    localparam logic [31:0] IR_ADD  = {5'd3, 4'd5, 4'd6, 4'd7, 15'd0};

    initial begin
        int reads, cyc;
        reset_v = '{1'b1, 1'b1};
        stop_v  = '{1'b0, 1'b0};
        ir_v    = '{32'h0, 32'h0};
        ticks(2);
        armed = 1'b1;
        lit("reset_all_zero", act[0], 64'h0);

        ir_v[0] = IR_SHRA; reset_v[0] = 1'b0;
        tick(); lit("shra_t0_fetch", {act[0].pc_out, act[0].mar_in, act[0].inc_pc, act[0].pc_in}, 4'hF);
        tick(); lit("shra_t1_read", {act[0].read, act[0].mdr_in}, 2'b11);
        tick(); lit("shra_t2_ir_in", {act[0].mdr_out, act[0].ir_in}, 2'b11);
        tick(); lit("shra_t3_reg_out", {act[0].reg_out, act[0].y_in}, {16'h0008, 1'b1});
        tick(); lit("shra_t4_reg_out", act[0].reg_out, 16'h0080);
                lit("shra_t4_alu_op", {act[0].alu_op, act[0].z_in}, {13'h0080, 1'b1});
        tick(); lit("shra_t5_reg_in", {act[0].reg_in, act[0].zlow_out}, {16'h0010, 1'b1});
        tick(); lit("shra_next_t0", act[0].pc_out, 1'b1);

        ir_v[0] = IR_MUL;
        ticks(3); lit("mul_t3_reg_out", act[0].reg_out, 16'h0008);
        tick();   lit("mul_t4", {act[0].reg_out, act[0].alu_op}, {16'h0002, 13'h0010});
        tick();   lit("mul_t5", {act[0].zlow_out, act[0].lo_in, act[0].reg_in}, {2'b11, 16'h0});
        tick();   lit("mul_t6", {act[0].zhigh_out, act[0].hi_in, act[0].reg_in}, {2'b11, 16'h0});
        tick();   lit("mul_next_t0", act[0].pc_out, 1'b1);

        ir_v[0] = IR_NEG;
        ticks(3); lit("neg_t3", {act[0].reg_out, act[0].alu_op, act[0].z_in}, {16'h0004, 13'h0800, 1'b1});
        tick();   lit("neg_t4", {act[0].reg_in, act[0].zlow_out}, {16'h0002, 1'b1});
        tick();   lit("neg_next_t0", act[0].pc_out, 1'b1);

        ir_v[0] = IR_ADD;
        ticks(4); stop_v[0] = 1'b1;
        tick();   lit("stop_t5_still_running", act[0].run, 1'b1);
        tick();   stop_v[0] = 1'b0;
        lit("stop_halt_run", act[0].run, 1'b0);
        ticks(3); lit("stop_halt_all_zero", act[0], 64'h0);

        reset_v[0] = 1'b1; ir_v[0] = 32'hD8000000;
        tick(); reset_v[0] = 1'b0;
        tick(); lit("halt_op_t0", act[0].pc_out, 1'b1);
        ticks(3); lit("halt_op_t3_run", act[0].run, 1'b1);
        tick();   lit("halt_op_halted", act[0].run, 1'b0);
        ticks(3); lit("halt_op_all_zero", act[0], 64'h0);

        reset_v[0] = 1'b1; ir_v[0] = 32'hF8000000;
        tick(); reset_v[0] = 1'b0;
        ticks(4); lit("illegal_t3", act[0].illegal, 1'b1);
        tick();   lit("illegal_next_t0", {act[0].illegal, act[0].pc_out}, 2'b01);

        ir_v[0] = IR_SHRA;
        ticks(4); reset_v[0] = 1'b1;
        tick();   lit("midreset_all_zero", act[0], 64'h0);
        reset_v[0] = 1'b0;
        tick();   lit("midreset_restart_t0", act[0].pc_out, 1'b1);

        reset_v[0] = 1'b1;
        ir_v[1] = IR_ADD; reset_v[1] = 1'b0;
        tick(); lit("w2_t0", act[1].pc_out, 1'b1);
        reads = 0; cyc = 0;
        do begin
            tick(); cyc++;
            if (act[1].read) reads++;
        end while (!act[1].pc_out && cyc < 20);
        lit("w2_read_cycles", reads, 3);
        lit("w2_t0_to_t0", cyc, 8);

        reset_v[0] = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (m_halt[k]) reset_v[k] = ($urandom_range(0, 2) == 0);
                else reset_v[k] = ($urandom_range(0, 299) == 0);
                stop_v[k] = ($urandom_range(0, 7) == 0);
                if (m_rst[k] || m_idx[k] == 0) ir_v[k] = rand_ir();
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hard-wired control unit that drives the single-bus datapath's control strobes.
- Sequences instruction fetch, then the register-format ALU instructions: ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG and NOT, plus NOP and HALT.
- Sits directly upstream of the datapath: it consumes the datapath's IR contents and produces every Rin/Rout/ALU/memory strobe.

Parameters:
- MEM_WAIT, 0: number of extra cycles T1 is held for memory read latency (0..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stop  in  1  request to halt at the next instruction boundary.
- ir  in  32  current IR contents; fields are opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
- pc_out, mar_in, inc_pc, pc_in  out  1 each  fetch strobes.
- read, mdr_in, mdr_out, ir_in  out  1 each  memory/IR strobes.
- y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  ALU path strobes.
- reg_in  out  16  one-hot register write enables (bit n = Rn).
- reg_out  out  16  one-hot register bus drivers.
- alu_op  out  13  one-hot operation select; bit order 0..12 = AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
- run  out  1  high while executing; low in RST and HALT.
- illegal  out  1  high for one cycle when an unmapped opcode is decoded.

Behaviour:
- Reset:
  - reset=1 at any rising edge forces state RST and wait_cnt=0, including mid-instruction.
  - In RST every output is 0.
  - RST moves to T0 on the next edge where reset=0.
- Outputs are a pure function of the present state, wait_cnt and ir. Strobes not listed for a state are 0.
- T0: pc_out, mar_in, inc_pc, pc_in.
- T1: read, mdr_in.
  - The state is held until wait_cnt==MEM_WAIT. wait_cnt increments each cycle in T1 and clears on exit.
  - With MEM_WAIT=0, T1 lasts exactly 1 cycle.
- T2: mdr_out, ir_in. IR is valid from T3 onward.
- T3, by opcode:
  - Two-operand ops (ADD 3, SUB 4, AND 5, OR 6, ROR 7, ROL 8, SHR 9, SHRA 10, SHL 11, DIV 15, MUL 16): reg_out=onehot(rb), y_in.
  - NEG 17 / NOT 18: reg_out=onehot(rb), alu_op[NEG/NOT], z_in.
  - NOP 26: no strobes; next state T0.
  - HALT 27: no strobes; next state HALT.
  - Any other opcode: illegal=1, no strobes, treated as NOP.
- T4:
  - Two-operand ops: reg_out=onehot(rc), matching alu_op bit, z_in.
  - NEG/NOT: zlow_out, reg_in=onehot(ra); instruction ends.
- T5:
  - Non-MUL/DIV two-operand ops: zlow_out, reg_in=onehot(ra); instruction ends.
  - MUL/DIV: zlow_out, lo_in.
- T6 (MUL/DIV only): zhigh_out, hi_in; instruction ends.
- Instruction end: next state is T0, or HALT if stop=1 at that edge. stop is sampled only at instruction end.
- HALT: all strobes 0, run=0. HALT is exited only by reset.
- Latency from T0: 6 cycles for two-operand ops, 7 for MUL/DIV, 5 for NEG/NOT, 4 for NOP; add MEM_WAIT in every case.
- Register fields:
  - R0 is addressed like any other register.
  - ra==rb or ra==rc is legal; no special handling.
- At most one bit of each of reg_in, reg_out and alu_op is set in any cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (values above);
  - state encoding: RST, T0..T6, HALT;
  - alu_op bit indices;
  - IR field bit positions.
- One sub-module, reg_select_decoder: 4-bit index plus enable in, 16-bit one-hot out. It is instanced twice, once for reg_in and once for reg_out.

Test Plan:
- Reset, then ir=0x521B8000 (SHRA R4,R3,R7), MEM_WAIT=0 -> T0 fetch strobes; T1 read+mdr_in; T2 mdr_out+ir_in; T3 reg_out=0x0008+y_in; T4 reg_out=0x0080, alu_op=bit7, z_in; T5 zlow_out, reg_in=0x0010; then T0.
- ir=0x80188000 (MUL R3,R1) -> T3 reg_out=0x0008; T4 reg_out=0x0002, alu_op=bit4; T5 zlow_out+lo_in; T6 zhigh_out+hi_in; reg_in stays 0 throughout.
- ir=0x88900000 (NEG R1,R2) -> T3 reg_out=0x0004, alu_op=bit11, z_in; T4 zlow_out, reg_in=0x0002; next T0.
- MEM_WAIT=2 with an ADD -> read and mdr_in held exactly 3 cycles; total 8 cycles T0..T0.
- stop pulsed during T4 of ADD, and separately ir opcode=27 -> stop pulse gives HALT after T5; opcode 27 gives HALT after T3; run=0 and strobes 0 until reset; opcode 31 -> illegal=1 for one cycle in T3, then T0.
- reset asserted during T4 of SHRA -> next cycle RST with all outputs 0; fetch restarts at T0 the cycle after reset deasserts.
